// File: rtl/display_convert_ctrl.sv
// rtl/display_convert_ctrl.sv - binary-to-BCD sequencing controller for the six-digit display
// Iterative double-dabble conversion with atomic digit commit, pending start and auto-sample trigger.
module display_convert_ctrl #(
    parameter int WIDTH         = 17,
    parameter int SAMPLE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] value_in,
    input  logic             start,
    input  logic             auto_en,
    input  logic             blank_en,
    output logic             busy,
    output logic             done,
    output logic [3:0]       digit0,
    output logic [3:0]       digit1,
    output logic [3:0]       digit2,
    output logic [3:0]       digit3,
    output logic [3:0]       digit4,
    output logic [3:0]       digit5,
    output logic [5:0]       blank_mask
);

    localparam int BCD_W = 24;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int TW    = $clog2(SAMPLE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic [WIDTH-1:0]  last_q, last_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [BCD_W-1:0]  digits_q, digits_d;
    logic [5:0]        mask_q, mask_d;
    logic              done_q, done_d;

    logic              tick;
    logic              trigger;
    logic [SR_W-1:0]   sr_adj;
    logic [BCD_W-1:0]  bcd;
    logic [5:0]        mask_new;
    logic              all_zero;

    assign tick    = (tick_q == TW'(SAMPLE_CYCLES - 1));
    assign trigger = start | pending_q | (auto_en & tick & (value_in != last_q));
    assign bcd     = sr_q[SR_W-1 -: BCD_W];
    assign tick_d  = tick ? '0 : tick_q + 1'b1;

    // Add-3 correction on every BCD nibble before the shift.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < 6; i++) begin
            if (sr_q[WIDTH+4*i +: 4] >= 4'd5)
                sr_adj[WIDTH+4*i +: 4] = sr_q[WIDTH+4*i +: 4] + 4'd3;
        end
    end

    // A digit blanks only while it and everything above it is zero; ones digit always shown.
    always_comb begin
        mask_new = '0;
        all_zero = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            all_zero    = all_zero & (bcd[4*i +: 4] == 4'd0);
            mask_new[i] = blank_en & all_zero;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        last_d    = last_q;
        digits_d  = digits_q;
        mask_d    = mask_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    sr_d      = {{BCD_W{1'b0}}, value_in};
                    last_d    = value_in;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_d  = sr_adj << 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(WIDTH - 1))
                    state_d = S_COMMIT;
                if (start)
                    pending_d = 1'b1;
            end
            S_COMMIT: begin
                digits_d = bcd;
                mask_d   = mask_new;
                done_d   = 1'b1;
                state_d  = S_IDLE;
                if (start)
                    pending_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            last_q    <= '0;
            tick_q    <= '0;
            digits_q  <= '0;
            mask_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            tick_q    <= tick_d;
            digits_q  <= digits_d;
            mask_q    <= mask_d;
            done_q    <= done_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign digit0     = digits_q[3:0];
    assign digit1     = digits_q[7:4];
    assign digit2     = digits_q[11:8];
    assign digit3     = digits_q[15:12];
    assign digit4     = digits_q[19:16];
    assign digit5     = digits_q[23:20];
    assign blank_mask = mask_q;

endmodule

// File: tb/tb_display_convert_ctrl.sv
// tb/tb_display_convert_ctrl.sv - scoreboard bench for display_convert_ctrl
module tb_display_convert_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [16:0] value_in;
    logic        start;
    logic        auto_en;
    logic        blank_en;
    logic        busy;
    logic        done;
    logic [3:0]  digit0, digit1, digit2, digit3, digit4, digit5;
    logic [5:0]  blank_mask;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          done_cnt = 0;
    logic [29:0] exp_q[$];

    display_convert_ctrl #(.WIDTH(17), .SAMPLE_CYCLES(20)) dut (
        .clk(clk), .reset_n(reset_n), .value_in(value_in), .start(start),
        .auto_en(auto_en), .blank_en(blank_en), .busy(busy), .done(done),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .digit4(digit4), .digit5(digit5), .blank_mask(blank_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {digit5..digit0, blank_mask} from plain decimal arithmetic.
    function automatic logic [29:0] model(input int v, input bit b);
        logic [3:0] d[6];
        logic [5:0] m;
        logic [23:0] dig;
        bit z;
        int div = 1;
        for (int i = 0; i < 6; i++) begin
            d[i] = 4'((v / div) % 10);
            div  = div * 10;
        end
        m = '0;
        z = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            z    = z && (d[i] == 4'd0);
            m[i] = b && z;
        end
        dig = {d[5], d[4], d[3], d[2], d[1], d[0]};
        return {dig, m};
    endfunction

    always @(negedge clk) begin
        if (reset_n && done) begin
            logic [29:0] e;
            done_cnt++;
            check("busy_with_done", {31'd0, busy}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("digits", {8'd0, digit5, digit4, digit3, digit2, digit1, digit0}, {8'd0, e[29:6]});
                check("blank_mask", {26'd0, blank_mask}, {26'd0, e[5:0]});
            end
        end
    end

    task automatic wait_done(input int bound);
        int c0 = done_cnt;
        int n  = 0;
        while (done_cnt == c0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == c0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input int v, input bit b);
        @(negedge clk);
        value_in = 17'(v);
        blank_en = b;
        exp_q.push_back(model(v, b));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40);
    endtask

    initial begin
        int cycles;
        reset_n  = 1'b0;
        value_in = '0;
        start    = 1'b0;
        auto_en  = 1'b0;
        blank_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_digits", {8'd0, digit5, digit4, digit3, digit2, digit1, digit0}, 32'd0);
        check("rst_mask", {26'd0, blank_mask}, 32'd0);
        reset_n = 1'b1;

        // Latency of a single conversion
        @(negedge clk);
        value_in = 17'd123456;
        exp_q.push_back(model(123456, 1'b0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_trigger", {31'd0, busy}, 32'd1);
        cycles = 0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        check("latency", 32'(cycles), 32'd18);

        run(131071, 1'b0);
        run(0, 1'b1);
        run(42, 1'b1);
        run(42, 1'b0);

        // Starts during a conversion merge into one pending request
        @(negedge clk);
        value_in = 17'd100;
        exp_q.push_back(model(100, 1'b0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        value_in = 17'd777;
        repeat (4) @(negedge clk);
        exp_q.push_back(model(777, 1'b0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pend_done_k18", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("pend_busy_k19", {31'd0, busy}, 32'd1);
        wait_done(40);
        repeat (40) @(negedge clk);

        // Auto-sample: one conversion per change of value_in
        value_in = 17'd9;
        exp_q.push_back(model(9, 1'b0));
        auto_en = 1'b1;
        wait_done(60);
        repeat (100) @(negedge clk);
        value_in = 17'd10;
        exp_q.push_back(model(10, 1'b0));
        wait_done(60);
        repeat (100) @(negedge clk);
        auto_en = 1'b0;

        // Reset mid-conversion aborts with no done pulse
        @(negedge clk);
        value_in = 17'd555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_digits", {8'd0, digit5, digit4, digit3, digit2, digit1, digit0}, 32'd0);
        reset_n = 1'b1;
        run(555, 1'b0);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/display_convert_ctrl.md
# display_convert_ctrl

Sequencing controller for the six-digit seven-segment display path. It samples a 17-bit binary value, runs an iterative shift-and-add-3 (double-dabble) binary-to-BCD conversion, and commits all six BCD digits atomically. The per-digit decoders are driven from these registered digits. Conversions are triggered by an explicit start pulse or automatically on a periodic sample tick when the input has changed. The block also produces a leading-zero blank mask.

## Interface

Parameters:
- WIDTH, 17, binary input width; fixed at 17 for six decimal digits (max 131071)
- SAMPLE_CYCLES, 50000, auto-sample tick period in clk cycles (must be ≥ 20)

Ports:
- clk  input  1  system clock, rising-edge
- reset_n  input  1  asynchronous, active-low reset
- value_in  input  17  binary value to display
- start  input  1  request a conversion of value_in; level sampled each edge
- auto_en  input  1  enables change-triggered conversion on sample ticks
- blank_en  input  1  enables leading-zero blanking; sampled at commit
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse; digits and blank_mask updated this cycle
- digit0..digit5  output  4 each  BCD digits, digit0 = ones, digit5 = hundred-thousands
- blank_mask  output  6  bit i = 1 means digit i should be blanked

## Operation

- States: IDLE, SHIFT, COMMIT.
- Trigger in IDLE on any of the following:
  - start = 1
  - pending = 1
  - auto trigger: auto_en = 1, tick = 1, and value_in != last_value
- Simultaneous trigger sources produce exactly one conversion.
- On trigger, the same edge does the following:
  - shift register ← {24'b0, value_in}
  - last_value ← value_in
  - iteration count ← 0
  - pending ← 0
  - state ← SHIFT
- SHIFT, each edge: every BCD nibble ≥ 5 gets +3, then the whole {bcd, bin} register shifts left by 1. This repeats for exactly 17 edges, then state ← COMMIT.
- COMMIT, one edge:
  - digit0..5 ← BCD nibbles
  - blank_mask is computed from the committed digits and blank_en
  - done ← 1
  - state ← IDLE
- Blanking, when blank_en = 1: digit i (i = 5 down to 1) is blanked iff digit i and every higher digit are 0. digit0 is never blanked. When blank_en = 0, blank_mask = 0.
- start seen while not in IDLE sets pending. One queued request at most; further starts merge into it. Pending is converted using value_in as sampled at that later trigger edge.
- Tick counter: free-running, counts 0..SAMPLE_CYCLES-1 and wraps. tick = 1 when the count equals SAMPLE_CYCLES-1. A tick that falls outside IDLE is dropped; it is not queued.
- digit and blank_mask outputs change only in COMMIT. They hold their old values throughout a conversion, so there is never a partial update.
- value_in changes during SHIFT do not affect the conversion in progress.

## Timing

- Reset values (asynchronous, while reset_n = 0):
  - state IDLE
  - busy 0, done 0
  - digits all 0, blank_mask 6'b000000
  - last_value 0, pending 0, tick counter 0
- Reset asserted mid-conversion aborts immediately. Digits return to 0 and no done pulse is produced.
- Latency: trigger accepted at edge k.
  - busy = 1 after edge k.
  - The 17 shifts occur at edges k+1..k+17.
  - Commit occurs at edge k+18: digits valid, done = 1 for exactly one cycle, busy = 0.
  - Total: 18 cycles from trigger edge to new digits.
- A new trigger can be accepted at edge k+19 at the earliest (IDLE needs one edge). A pending start is therefore accepted at k+19.
- busy and done are never high in the same cycle.
- With auto_en = 1 and a constant value_in, no conversion occurs after the first one that matches.

## Test plan

- Reset, then start pulse with value_in = 123456 → busy high 18 cycles; done at edge k+18; digits 5..0 = 1,2,3,4,5,6; blank_mask = 0.
- value_in = 131071 (max), start → digits 1,3,1,0,7,1. Then value_in = 0 with blank_en = 1, start → digits all 0, blank_mask = 6'b111110.
- value_in = 42 with blank_en = 1, start → digits 0,0,0,0,4,2; blank_mask = 6'b111100. Repeat with blank_en = 0 → blank_mask = 0.
- start asserted at edges k+3 and k+9 during a conversion of 100 → exactly one extra conversion, accepted at edge k+19. value_in changed to 777 at k+5 → first result 100, second result 777.
- SAMPLE_CYCLES = 20, auto_en = 1, value_in = 9 held constant → one conversion only. Change to 10 → next tick converts; no conversion on later ticks.
- reset_n pulsed low at edge k+8 of a conversion of 555 → digits 0, busy 0, no done pulse. After release, start converts 555 normally.
